// File: rtl/uart_pkg.sv
// Shared UART receive definitions: rx FSM state type and default framing parameters.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
    localparam int unsigned DATA_BITS_DEFAULT    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_i,
    output logic rx_s_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: finds start bits, strobes data bits LSB first to a SIPO and flags framing errors.
// Optional parity bit checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic bit_data,
    output logic bit_valid,
    output logic frame_done,
    output logic frame_err,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1)
    begin : g_bad_cfg
        $error("uart_rx_framer: unsupported parameter set");
    end

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_acc_q;
    logic             par_err_q;
`endif

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .rx_i   (rx_in),
        .rx_s_o (rx_s)
    );

    // Receive FSM; every sample point is the last cycle of a counted bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            bit_data   <= 1'b0;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_acc_q <= 1'b0;
                        par_err_q <= 1'b0;
`endif
                    end
                end
                // Mid-start-bit recheck rejects glitches shorter than half a bit.
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        bit_data  <= rx_s;
                        bit_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_acc_q <= par_acc_q ^ rx_s;
`endif
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= ST_PARITY;
`else
                            state_q   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q     <= '0;
                        par_err_q <= (par_acc_q ^ rx_s) != 1'(PARITY_ODD);
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q      <= '0;
                        frame_done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        frame_err  <= ~rx_s | par_err_q;
`else
                        frame_err  <= ~rx_s;
`endif
                        state_q    <= rx_s ? ST_IDLE : ST_BREAK;
                        busy       <= ~rx_s;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // Line held low past the stop bit: wait for it to return idle.
                ST_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
